// File: rtl/cdd_stream_pkg.sv
`default_nettype none
// ============================================================================
// cdd_stream_pkg : shared types and constants for the CD data stream path.
// Revision: 1.0
// ============================================================================
package cdd_stream_pkg;

  localparam int unsigned SECT_WORDS = 1176;
  localparam int unsigned IDX_W      = 11;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SECT_WORDS - 1);

  localparam int unsigned CDW_AUDIO  = 17;
  localparam int unsigned CDW_DOUBLE = 16;

  typedef struct packed {
    logic        audio;
    logic        dbl;
    logic [15:0] data;
  } cdd_word_t;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    PLAYING = 2'd2
  } bank_state_t;

  function automatic cdd_word_t make_word(input logic audio, input logic dbl,
                                          input logic [15:0] data);
    logic [17:0] w;
    w             = '0;
    w[CDW_AUDIO]  = audio;
    w[CDW_DOUBLE] = dbl;
    w[15:0]       = data;
    return cdd_word_t'(w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdd_stream_pacer.sv
`default_nettype none
// ============================================================================
// cdd_stream_pacer : fractional divider producing one-cycle word ticks at
// WORD_HZ (or 2x WORD_HZ) from CLK_HZ.
// Revision: 1.0
// ============================================================================
module cdd_stream_pacer #(
  parameter int unsigned CLK_HZ  = 53693175,
  parameter int unsigned WORD_HZ = 88200
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic DOUBLE,
  input  logic RUN,
  output logic TICK
);

  localparam int unsigned ACC_W = 27;
  localparam logic [ACC_W-1:0] STEP_1X = ACC_W'(WORD_HZ);
  localparam logic [ACC_W-1:0] STEP_2X = ACC_W'(2 * WORD_HZ);
  localparam logic [ACC_W-1:0] WRAP    = ACC_W'(CLK_HZ);

  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic             tick_q, tick_d;

  always_comb begin
    sum    = acc_q + (DOUBLE ? STEP_2X : STEP_1X);
    acc_d  = sum;
    tick_d = 1'b0;
    if (!RUN) begin
      acc_d = '0;
    end else if (sum >= WRAP) begin
      acc_d  = sum - WRAP;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign TICK = tick_q;

endmodule
`default_nettype wire

// File: rtl/cdd_stream_tx.sv
`default_nettype none
// ============================================================================
// cdd_stream_tx : plays raw 2352-byte sectors from a two-bank ping-pong RAM
// as paced 18-bit CD_D words. Option macro: CDD_STREAM_SILENCE_EN.
// Revision: 1.0
// ============================================================================
module cdd_stream_tx
  import cdd_stream_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 53693175,
  parameter int unsigned WORD_HZ = 88200,
  parameter int unsigned CK_HIGH = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN,
  input  logic        LD_WE,
  input  logic [10:0] LD_ADDR,
  input  logic [15:0] LD_DATA,
  input  logic        LD_COMMIT,
  input  logic        LD_AUDIO,
  input  logic        LD_DOUBLE,
  output logic        LD_READY,
  output logic [17:0] CD_D,
  output logic        CD_CK,
  output logic        BUSY,
  output logic        SECT_DONE,
  output logic        UNDERRUN
);

  localparam int unsigned CNT_W = $clog2(CK_HIGH + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_WORD = 3'd1,
    S_WAIT_TICK = 3'd2,
    S_STROBE    = 3'd3,
    S_SILENCE   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  bank_state_t      bank_q [2];
  bank_state_t      bank_d [2];
  logic [1:0]       audio_q, audio_d, dbl_q, dbl_d;
  logic             play_bank_q, play_bank_d, next_q, next_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cdd_word_t        cd_d_q, cd_d_d;
  logic             cd_ck_q, cd_ck_d, done_q, done_d, under_q, under_d;

  logic [15:0] mem [2][SECT_WORDS];
  logic [15:0] rd_word_q;

  logic [1:0] full;
  logic       ld_ready, ld_bank, wr_en, commit, busy, other, other_ready;
  logic       tick, pace_run, pace_dbl;

  assign full[0]     = (bank_q[0] == FULL);
  assign full[1]     = (bank_q[1] == FULL);
  assign ld_ready    = (bank_q[0] == EMPTY) || (bank_q[1] == EMPTY);
  assign ld_bank     = (bank_q[0] == EMPTY) ? 1'b0 : 1'b1;
  assign wr_en       = LD_WE && ld_ready && (LD_ADDR <= LAST_IDX);
  assign commit      = LD_COMMIT && ld_ready;
  assign busy        = (state_q != S_IDLE) && (state_q != S_SILENCE);
  assign other       = ~play_bank_q;
  // A commit landing on the last strobe still counts as a queued sector.
  assign other_ready = full[other] || (commit && (ld_bank == other));

`ifdef CDD_STREAM_SILENCE_EN
  assign pace_run = EN;
`else
  assign pace_run = EN && (busy || (|full));
`endif
  assign pace_dbl = busy ? dbl_q[play_bank_q] : (full[next_q] && dbl_q[next_q]);

  cdd_stream_pacer #(
    .CLK_HZ  (CLK_HZ),
    .WORD_HZ (WORD_HZ)
  ) u_pacer (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .DOUBLE (pace_dbl),
    .RUN    (pace_run),
    .TICK   (tick)
  );

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    audio_d     = audio_q;
    dbl_d       = dbl_q;
    play_bank_d = play_bank_q;
    next_d      = next_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    cd_d_d      = cd_d_q;
    cd_ck_d     = 1'b0;
    done_d      = 1'b0;
    under_d     = 1'b0;

    if (commit) begin
      bank_d[ld_bank]  = FULL;
      audio_d[ld_bank] = LD_AUDIO;
      dbl_d[ld_bank]   = LD_DOUBLE;
      if (!full[~ld_bank]) next_d = ld_bank;
    end

    case (state_q)
      S_IDLE: begin
        if (full[next_q] && EN) begin
          bank_d[next_q] = PLAYING;
          play_bank_d    = next_q;
          next_d         = ~next_q;
          idx_d          = '0;
          state_d        = S_LOAD_WORD;
        end
`ifdef CDD_STREAM_SILENCE_EN
        else if (tick && EN) begin
          cd_d_d  = make_word(1'b1, 1'b0, 16'h0000);
          cnt_d   = '0;
          state_d = S_SILENCE;
        end
`endif
      end
      S_LOAD_WORD: state_d = S_WAIT_TICK;
      S_WAIT_TICK: begin
        if (tick && EN) begin
          cd_d_d  = make_word(audio_q[play_bank_q], dbl_q[play_bank_q], rd_word_q);
          cnt_d   = '0;
          state_d = S_STROBE;
        end
      end
      S_STROBE, S_SILENCE: begin
        if (cnt_q != CNT_W'(CK_HIGH)) begin
          cd_ck_d = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
        end else if (state_q == S_SILENCE) begin
          state_d = S_IDLE;
        end else if (idx_q != LAST_IDX) begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_WAIT_TICK;
        end else begin
          bank_d[play_bank_q] = EMPTY;
          done_d              = 1'b1;
          if (other_ready) begin
            bank_d[other] = PLAYING;
            play_bank_d   = other;
            next_d        = play_bank_q;
            idx_d         = '0;
            state_d       = S_WAIT_TICK;
          end else begin
            under_d = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      bank_q      <= '{EMPTY, EMPTY};
      audio_q     <= '0;
      dbl_q       <= '0;
      play_bank_q <= 1'b0;
      next_q      <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      cd_d_q      <= '0;
      cd_ck_q     <= 1'b0;
      done_q      <= 1'b0;
      under_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      audio_q     <= audio_d;
      dbl_q       <= dbl_d;
      play_bank_q <= play_bank_d;
      next_q      <= next_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      cd_d_q      <= cd_d_d;
      cd_ck_q     <= cd_ck_d;
      done_q      <= done_d;
      under_q     <= under_d;
    end
  end

  // Read uses the next index so rd_word_q always matches idx_q's word.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[ld_bank][LD_ADDR] <= LD_DATA;
    rd_word_q <= mem[play_bank_d][idx_d];
  end

  assign LD_READY  = ld_ready;
  assign CD_D      = cd_d_q;
  assign CD_CK     = cd_ck_q;
  assign BUSY      = busy;
  assign SECT_DONE = done_q;
  assign UNDERRUN  = under_q;

endmodule
`default_nettype wire

// File: tb/tb_cdd_stream_tx.sv
`default_nettype none
// ============================================================================
// tb_cdd_stream_tx : directed bench for cdd_stream_tx, scaled-down clock so a
// full sector plays in a few thousand cycles (1x = 10.5 CLK, 2x = 5.25 CLK).
// Revision: 1.0
// ============================================================================
module tb_cdd_stream_tx;

  localparam int unsigned CLK_HZ  = 1050;
  localparam int unsigned WORD_HZ = 100;
  localparam int unsigned CK_HIGH = 2;
  localparam int NW = 1176;

  logic        CLK = 1'b0, RST_N = 1'b0, EN = 1'b0;
  logic        LD_WE = 1'b0, LD_COMMIT = 1'b0, LD_AUDIO = 1'b0, LD_DOUBLE = 1'b0;
  logic [10:0] LD_ADDR = '0;
  logic [15:0] LD_DATA = '0;
  logic        LD_READY, CD_CK, BUSY, SECT_DONE, UNDERRUN;
  logic [17:0] CD_D;

  cdd_stream_tx #(
    .CLK_HZ  (CLK_HZ),
    .WORD_HZ (WORD_HZ),
    .CK_HIGH (CK_HIGH)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .EN        (EN),
    .LD_WE     (LD_WE),
    .LD_ADDR   (LD_ADDR),
    .LD_DATA   (LD_DATA),
    .LD_COMMIT (LD_COMMIT),
    .LD_AUDIO  (LD_AUDIO),
    .LD_DOUBLE (LD_DOUBLE),
    .LD_READY  (LD_READY),
    .CD_D      (CD_D),
    .CD_CK     (CD_CK),
    .BUSY      (BUSY),
    .SECT_DONE (SECT_DONE),
    .UNDERRUN  (UNDERRUN)
  );

  always #5 CLK = ~CLK;

  logic [17:0] ed_d[$];
  int          ed_t[$];
  int          cyc = 0, n_done = 0, n_und = 0;
  logic        ck_prev = 1'b0;
  int          n_chk = 0, n_bad = 0;

  initial forever begin
    @(posedge CLK);
    #1;
    cyc++;
    if (CD_CK && !ck_prev) begin
      ed_d.push_back(CD_D);
      ed_t.push_back(cyc);
    end
    ck_prev = CD_CK;
    if (SECT_DONE) n_done++;
    if (UNDERRUN) n_und++;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_chk++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic load(input logic [15:0] mask);
    for (int i = 0; i < NW; i++) begin
      @(negedge CLK);
      LD_WE   = 1'b1;
      LD_ADDR = 11'(i);
      LD_DATA = 16'(i) ^ mask;
    end
    @(negedge CLK);
    LD_WE = 1'b0;
  endtask

  task automatic do_commit(input logic a, input logic d);
    @(negedge CLK);
    LD_COMMIT = 1'b1;
    LD_AUDIO  = a;
    LD_DOUBLE = d;
    @(negedge CLK);
    LD_COMMIT = 1'b0;
  endtask

  task automatic clear_mon();
    ed_d.delete();
    ed_t.delete();
    n_done = 0;
    n_und  = 0;
  endtask

  task automatic wait_und(input int target, input int budget, input string nm);
    int k = 0;
    while (n_und < target && k < budget) begin
      @(posedge CLK);
      #2;
      k++;
    end
    chk(nm, 32'(n_und >= target), 32'd1);
  endtask

  task automatic wait_edges(input int target, input int budget, input string nm);
    int k = 0;
    while (ed_d.size() < target && k < budget) begin
      @(posedge CLK);
      #2;
      k++;
    end
    chk(nm, 32'(ed_d.size() >= target), 32'd1);
  endtask

  task automatic check_stream(input string nm, input int base, input logic [15:0] mask,
                              input logic [1:0] fl, input int sp_lo, input int sp_hi);
    int errs = 0;
    int mn = 1 << 30;
    int mx = 0;
    int s;
    logic [17:0] exp_w;
    if (ed_d.size() < base + NW) begin
      chk({nm, " stream length"}, 32'(ed_d.size()), 32'(base + NW));
      return;
    end
    for (int i = 0; i < NW; i++) begin
      exp_w = {fl, 16'(i) ^ mask};
      if (ed_d[base+i] !== exp_w) errs++;
      if (i > 0) begin
        s = ed_t[base+i] - ed_t[base+i-1];
        if (s < mn) mn = s;
        if (s > mx) mx = s;
      end
    end
    chk({nm, " word errors"}, 32'(errs), 32'd0);
    chk_rng({nm, " min spacing"}, mn, sp_lo, sp_hi);
    chk_rng({nm, " max spacing"}, mx, sp_lo, sp_hi);
  endtask

  typedef struct {
    logic        audio;
    logic        dbl;
    logic [15:0] mask;
    int          sp_lo;
    int          sp_hi;
    int          dur_lo;
    int          dur_hi;
  } vec_t;

  initial begin
    vec_t vt[3];
    string nm;
    vt[0] = '{1'b0, 1'b0, 16'h0000, 10, 11, 12337, 12338};
    vt[1] = '{1'b1, 1'b1, 16'hA5A5,  5,  6,  6168,  6169};
    vt[2] = '{1'b0, 1'b1, 16'hF800,  5,  6,  6168,  6169};

    repeat (3) @(posedge CLK);
    #2;
    chk("reset CD_D", 32'(CD_D), 32'd0);
    chk("reset CD_CK", 32'(CD_CK), 32'd0);
    chk("reset BUSY", 32'(BUSY), 32'd0);
    chk("reset SECT_DONE", 32'(SECT_DONE), 32'd0);
    chk("reset UNDERRUN", 32'(UNDERRUN), 32'd0);
    chk("reset LD_READY", 32'(LD_READY), 32'd1);
    @(negedge CLK);
    RST_N = 1'b1;
    EN    = 1'b1;

    // Idle with no sector queued.
    clear_mon();
    repeat (2000) @(posedge CLK);
    #2;
`ifdef CDD_STREAM_SILENCE_EN
    chk_rng("idle silence edge count", ed_d.size(), 180, 200);
    chk("idle silence word", (ed_d.size() > 0) ? 32'(ed_d[0]) : 32'hFFFF_FFFF, 32'h0002_0000);
`else
    chk("idle edge count", 32'(ed_d.size()), 32'd0);
`endif

    // Single sectors at 1x and 2x.
    for (int v = 0; v < 3; v++) begin
      load(vt[v].mask);
      clear_mon();
      do_commit(vt[v].audio, vt[v].dbl);
      nm = $sformatf("vec%0d", v);
      wait_und(1, 20000, {nm, " completes"});
      repeat (3) @(posedge CLK);
      #2;
      chk({nm, " edge count"}, 32'(ed_d.size()), 32'(NW));
      check_stream(nm, 0, vt[v].mask, {vt[v].audio, vt[v].dbl}, vt[v].sp_lo, vt[v].sp_hi);
      if (ed_t.size() >= NW)
        chk_rng({nm, " duration"}, ed_t[NW-1] - ed_t[0], vt[v].dur_lo, vt[v].dur_hi);
      chk({nm, " SECT_DONE count"}, 32'(n_done), 32'd1);
      chk({nm, " UNDERRUN count"}, 32'(n_und), 32'd1);
      chk({nm, " BUSY after"}, 32'(BUSY), 32'd0);
      chk({nm, " LD_READY after"}, 32'(LD_READY), 32'd1);
    end

    // Back-to-back sectors A (bank 0) then B (bank 1), loaded during A.
    load(16'h4000);
    clear_mon();
    do_commit(1'b1, 1'b1);
    chk("ab LD_READY during A", 32'(LD_READY), 32'd1);
    load(16'h8000);
    do_commit(1'b0, 1'b1);
    chk("ab LD_READY after B commit", 32'(LD_READY), 32'd0);
    @(negedge CLK);
    LD_WE   = 1'b1;
    LD_ADDR = 11'd0;
    LD_DATA = 16'hBEEF;
    @(negedge CLK);
    LD_WE = 1'b0;
    wait_und(1, 30000, "ab completes");
    repeat (3) @(posedge CLK);
    #2;
    chk("ab edge count", 32'(ed_d.size()), 32'(2 * NW));
    check_stream("ab A", 0, 16'h4000, 2'b11, 5, 6);
    check_stream("ab B", NW, 16'h8000, 2'b01, 5, 6);
    if (ed_t.size() > NW)
      chk_rng("ab A-to-B gap", ed_t[NW] - ed_t[NW-1], 5, 6);
    chk("ab SECT_DONE count", 32'(n_done), 32'd2);
    chk("ab UNDERRUN count", 32'(n_und), 32'd1);

    // Pause at word 500.
    load(16'h3333);
    clear_mon();
    do_commit(1'b0, 1'b1);
    wait_edges(500, 10000, "pause reaches word 500");
    EN = 1'b0;
    repeat (2000) @(posedge CLK);
    #2;
    chk("pause edge count held", 32'(ed_d.size()), 32'd500);
    chk("pause BUSY held", 32'(BUSY), 32'd1);
    EN = 1'b1;
    wait_und(1, 20000, "pause completes");
    repeat (3) @(posedge CLK);
    #2;
    chk("pause edge count", 32'(ed_d.size()), 32'(NW));
    chk("pause resume word", (ed_d.size() > 500) ? 32'(ed_d[500]) : 32'hFFFF_FFFF,
        32'({2'b01, 16'd500 ^ 16'h3333}));
    check_stream("pause", 0, 16'h3333, 2'b01, 5, 100000);

    // Reset at word 300, then restart from stale bank data.
    load(16'h0F0F);
    clear_mon();
    do_commit(1'b1, 1'b1);
    wait_edges(300, 5000, "reset reaches word 300");
    RST_N = 1'b0;
    #1;
    chk("midreset CD_CK", 32'(CD_CK), 32'd0);
    chk("midreset BUSY", 32'(BUSY), 32'd0);
    chk("midreset LD_READY", 32'(LD_READY), 32'd1);
    chk("midreset CD_D", 32'(CD_D), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    clear_mon();
    do_commit(1'b1, 1'b1);
    wait_edges(5, 200, "restart emits words");
    chk("restart word 0", (ed_d.size() > 0) ? 32'(ed_d[0]) : 32'hFFFF_FFFF, 32'h0003_0F0F);
    chk("restart word 4", (ed_d.size() > 4) ? 32'(ed_d[4]) : 32'hFFFF_FFFF, 32'h0003_0F0B);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
